// File: rtl/sisc_fetch.sv
// sisc_fetch: SISC instruction fetch stage.
// Holds the PC, fetches 32-bit words over a req/ack handshake, and presents
// the registered instruction (ir/ir_valid/pc_out) to the execute datapath.
// Ports: clk, rst_f (sync, active-low); next/br_taken/br_abs/br_imm from
// ctrl; imem_addr/imem_req/imem_ack/imem_rdata to instruction memory;
// ir/ir_valid/pc_out to execute.
// Option: SISC_FETCH_PREFETCH_EN adds a one-entry prefetch buffer.
module sisc_fetch #(
  parameter int              PC_W     = 16,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst_f,
  input  logic            next,
  input  logic            br_taken,
  input  logic            br_abs,
  input  logic [15:0]     br_imm,
  output logic [PC_W-1:0] imem_addr,
  output logic            imem_req,
  input  logic            imem_ack,
  input  logic [31:0]     imem_rdata,
  output logic [31:0]     ir,
  output logic            ir_valid,
  output logic [PC_W-1:0] pc_out
);

`ifdef SISC_FETCH_PREFETCH_EN
  localparam bit PF_EN = 1'b1;
`else
  localparam bit PF_EN = 1'b0;
`endif

  typedef enum logic [1:0] {
    S_RST,
    S_REQ,
    S_FULL
  } state_t;

  state_t          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [31:0]     ir_q, ir_d;
  logic            ir_valid_q, ir_valid_d;
  logic [PC_W-1:0] pc_out_q, pc_out_d;
  logic            pf_valid_q, pf_valid_d;
  logic [31:0]     pf_data_q, pf_data_d;
  logic            drop_q, drop_d;
  logic [PC_W-1:0] drop_addr_q, drop_addr_d;

  logic [PC_W+15:0] sx_w;
  logic [PC_W+15:0] zx_w;
  logic [PC_W-1:0]  pc_inc;
  logic [PC_W-1:0]  br_tgt;
  logic [PC_W-1:0]  next_pc;
  logic             take;
  logic             pf_hit;

  // Immediate widened to at least PC_W bits, then cut to PC_W.
  assign sx_w    = {{PC_W{br_imm[15]}}, br_imm};
  assign zx_w    = {{PC_W{1'b0}}, br_imm};
  assign pc_inc  = pc_q + PC_W'(1);
  assign br_tgt  = br_abs ? zx_w[PC_W-1:0]
                          : pc_inc + sx_w[PC_W-1:0];
  assign next_pc = br_taken ? br_tgt : pc_inc;
  assign take    = next & ir_valid_q;

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    ir_d        = ir_q;
    ir_valid_d  = ir_valid_q;
    pc_out_d    = pc_out_q;
    pf_valid_d  = pf_valid_q;
    pf_data_d   = pf_data_q;
    drop_d      = drop_q;
    drop_addr_d = drop_addr_q;
    imem_req    = 1'b0;
    imem_addr   = pc_q;
    pf_hit      = 1'b0;
    unique case (state_q)
      S_RST: begin
        state_d = S_REQ;
      end
      S_REQ: begin
        imem_req = 1'b1;
        // Finish an abandoned prefetch before issuing the target.
        if (drop_q) imem_addr = drop_addr_q;
        if (imem_ack) begin
          if (drop_q) begin
            drop_d = 1'b0;
          end else begin
            ir_d       = imem_rdata;
            ir_valid_d = 1'b1;
            pc_out_d   = pc_q;
            state_d    = S_FULL;
          end
        end
      end
      S_FULL: begin
        imem_req = PF_EN && !pf_valid_q;
        if (PF_EN) imem_addr = pc_inc;
        pf_hit = imem_req && imem_ack;
        if (take) begin
          pc_d       = next_pc;
          pf_valid_d = 1'b0;
          if (!br_taken && pf_valid_q) begin
            ir_d     = pf_data_q;
            pc_out_d = pc_inc;
          end else if (!br_taken && pf_hit) begin
            ir_d     = imem_rdata;
            pc_out_d = pc_inc;
          end else begin
            ir_valid_d = 1'b0;
            state_d    = S_REQ;
            // Sequential case keeps the same address on the bus; a branch
            // must drain the outstanding fetch first.
            if (br_taken && imem_req && !imem_ack) begin
              drop_d      = 1'b1;
              drop_addr_d = pc_inc;
            end
          end
        end else if (pf_hit) begin
          pf_data_d  = imem_rdata;
          pf_valid_d = 1'b1;
        end
      end
      default: begin
        state_d = S_RST;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_f) begin
      state_q     <= S_RST;
      pc_q        <= RESET_PC;
      ir_q        <= '0;
      ir_valid_q  <= 1'b0;
      pc_out_q    <= RESET_PC;
      pf_valid_q  <= 1'b0;
      pf_data_q   <= '0;
      drop_q      <= 1'b0;
      drop_addr_q <= RESET_PC;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      ir_q        <= ir_d;
      ir_valid_q  <= ir_valid_d;
      pc_out_q    <= pc_out_d;
      pf_valid_q  <= pf_valid_d;
      pf_data_q   <= pf_data_d;
      drop_q      <= drop_d;
      drop_addr_q <= drop_addr_d;
    end
  end

  assign ir       = ir_q;
  assign ir_valid = ir_valid_q;
  assign pc_out   = pc_out_q;

endmodule

// File: tb/tb_sisc_fetch.sv
// tb_sisc_fetch: randomized self-checking bench for sisc_fetch.
// Memory returns {16'hA5A5, addr}; an architectural PC model predicts ir.
module tb_sisc_fetch;

  logic        clk = 1'b0;
  logic        rst_f = 1'b0;
  logic        next = 1'b0;
  logic        br_taken = 1'b0;
  logic        br_abs = 1'b0;
  logic [15:0] br_imm = '0;
  logic [15:0] imem_addr;
  logic        imem_req;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic [31:0] ir;
  logic        ir_valid;
  logic [15:0] pc_out;

  int vectors = 0;
  int miscompares = 0;

  int   wait_fix = 0;
  logic late_ack = 1'b0;
  bit   spur = 1'b0;
  logic [15:0] exp_pc;
`ifdef SISC_FETCH_PREFETCH_EN
  localparam int BUB = 0;
`else
  localparam int BUB = 1;
`endif

  sisc_fetch #(.PC_W(16), .RESET_PC(16'h0000)) dut (
    .clk        (clk),
    .rst_f      (rst_f),
    .next       (next),
    .br_taken   (br_taken),
    .br_abs     (br_abs),
    .br_imm     (br_imm),
    .imem_addr  (imem_addr),
    .imem_req   (imem_req),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .ir         (ir),
    .ir_valid   (ir_valid),
    .pc_out     (pc_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] word(input logic [15:0] a);
    return {16'hA5A5, a};
  endfunction

  // Memory model: responds just after each rising edge.
  bit          busy = 1'b0;
  int          cnt = 0;
  int          tgt = 0;
  logic [15:0] addr0 = '0;
  logic [31:0] prev_ir = '0;

  always @(posedge clk) begin
    #1;
`ifndef SISC_FETCH_PREFETCH_EN
    if (rst_f && ir !== prev_ir) chk("ir_on_ack", imem_ack, 1'b1);
`endif
    prev_ir = ir;
    if (!rst_f) begin
      busy       = 1'b0;
      imem_ack   = late_ack;
      imem_rdata = 32'hDEADBEEF;
    end else begin
      if (imem_ack) busy = 1'b0;
      if (busy) chk("req_held", imem_req, 1'b1);
      if (imem_req) begin
        if (!busy) begin
          busy  = 1'b1;
          cnt   = 0;
          tgt   = (wait_fix >= 0) ? wait_fix : int'($urandom_range(0, 3));
          addr0 = imem_addr;
        end else begin
          cnt++;
          chk("addr_stable", imem_addr, addr0);
        end
        imem_ack   = (cnt == tgt);
        imem_rdata = word(imem_addr);
      end else begin
        imem_ack = 1'b0;
        busy     = 1'b0;
      end
    end
  end

  function automatic logic [15:0] model_pc(input logic [15:0] pc,
      input bit tk, input bit ab, input logic [15:0] imm);
    int t;
    if (!tk) t = int'(pc) + 1;
    else if (ab) t = int'(imm);
    else t = int'(pc) + 1 + int'($signed(imm));
    return 16'(t & 32'hFFFF);
  endfunction

  // Retire the current instruction and wait for the following one.
  task automatic retire(input bit tk, input bit ab, input logic [15:0] imm,
                        output int bub);
    next     = 1'b1;
    br_taken = tk;
    br_abs   = ab;
    br_imm   = imm;
    exp_pc   = model_pc(exp_pc, tk, ab, imm);
    @(negedge clk);
    next = 1'b0;
    bub  = 0;
    while (!ir_valid && bub < 50) begin
      bub++;
      if (spur) begin
        next     = 1'($urandom);
        br_taken = 1'($urandom);
        br_abs   = 1'($urandom);
        br_imm   = 16'($urandom);
      end
      @(negedge clk);
      next = 1'b0;
    end
    if (bub >= 50) chk("timeout", 1'b0, 1'b1);
    chk("pc_out", pc_out, exp_pc);
    chk("ir", ir, word(exp_pc));
  endtask

  initial begin
    int b;
    late_ack = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_ir", ir, 32'h0);
    chk("rst_valid", ir_valid, 1'b0);
    chk("rst_req", imem_req, 1'b0);
    chk("rst_pc_out", pc_out, 16'h0);
    chk("rst_addr", imem_addr, 16'h0);

    rst_f    = 1'b1;
    late_ack = 1'b0;
    @(negedge clk);
    chk("rel1_valid", ir_valid, 1'b0);
    chk("rel1_req", imem_req, 1'b1);
    @(negedge clk);
    chk("rel2_valid", ir_valid, 1'b1);
    chk("rel2_ir", ir, 32'hA5A50000);
    chk("rel2_pc_out", pc_out, 16'h0);
    exp_pc = 16'h0;

    for (int i = 1; i <= 3; i++) begin
      retire(1'b0, 1'b0, 16'h0, b);
      chk("seq_bubbles", 32'(b), 32'(BUB));
    end

    retire(1'b1, 1'b1, 16'h0010, b);
    retire(1'b1, 1'b0, 16'hFFFC, b);
    chk("rel_tgt", pc_out, 16'h000D);
    retire(1'b1, 1'b1, 16'h0010, b);
    retire(1'b1, 1'b1, 16'h0040, b);
    chk("abs_tgt", pc_out, 16'h0040);
    retire(1'b1, 1'b1, 16'hFFFF, b);
    retire(1'b0, 1'b0, 16'h0, b);
    chk("wrap", pc_out, 16'h0000);

    wait_fix = -1;
    spur     = 1'b1;
    repeat (300) begin
      repeat ($urandom_range(0, 2)) begin
        br_taken = 1'($urandom);
        br_abs   = 1'($urandom);
        br_imm   = 16'($urandom);
        @(negedge clk);
        chk("hold_ir", ir, word(exp_pc));
      end
      retire(($urandom_range(0, 3) == 0), 1'($urandom), 16'($urandom), b);
    end
    spur = 1'b0;

    wait_fix = 3;
    next     = 1'b1;
    br_taken = 1'b0;
    @(negedge clk);
    next = 1'b0;
    b    = 0;
    while (!imem_req && b < 10) begin
      b++;
      @(negedge clk);
    end
    chk("mid_req_seen", imem_req, 1'b1);
    rst_f    = 1'b0;
    late_ack = 1'b1;
    @(negedge clk);
    chk("mid_rst_req", imem_req, 1'b0);
    chk("mid_rst_valid", ir_valid, 1'b0);
    chk("mid_rst_ir", ir, 32'h0);
    @(negedge clk);
    chk("mid_rst_req2", imem_req, 1'b0);
    chk("mid_rst_pc_out", pc_out, 16'h0);
    rst_f    = 1'b1;
    late_ack = 1'b0;
    for (int i = 0; i < 4; i++) begin
      next     = 1'b1;
      br_taken = 1'b1;
      br_abs   = 1'b1;
      br_imm   = 16'h1234;
      @(negedge clk);
      chk("ws_req", imem_req, 1'b1);
      chk("ws_addr", imem_addr, 16'h0);
      chk("ws_valid", ir_valid, 1'b0);
    end
    next     = 1'b0;
    br_taken = 1'b0;
    @(negedge clk);
    chk("ws_done_valid", ir_valid, 1'b1);
    chk("ws_done_ir", ir, 32'hA5A50000);
    chk("ws_done_pc_out", pc_out, 16'h0);
    exp_pc = 16'h0;

    wait_fix = -1;
    repeat (5) retire(1'b0, 1'b0, 16'h0, b);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
